// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: a - b one digit per cycle, LSD first, with a
// ten's-complement pass that turns a negative partial result into its magnitude.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_part;
  logic [IW-1:0]   r_idx;
  logic            r_borrow;

  logic [3:0]      w_x, w_y, w_digit;
  logic [4:0]      w_diff;
  logic            w_bout, w_last, w_bad;
  logic [W-1:0]    w_part_next;

  // One shared digit subtractor: SUB computes a_i - b_i, COMP computes 0 - R_i.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_x = 4'd0;
    w_y = r_b[r_idx*4 +: 4];
    if (r_state == COMP) begin
      w_y = r_part[r_idx*4 +: 4];
    end else begin
      w_x = r_a[r_idx*4 +: 4];
    end
    w_diff  = {1'b0, w_x} - {1'b0, w_y} - {4'd0, r_borrow};
    w_bout  = w_diff[4];
    w_digit = w_bout ? (w_diff[3:0] + 4'd10) : w_diff[3:0];
    w_part_next = r_part;
    w_part_next[r_idx*4 +: 4] = w_digit;
    w_last = (r_idx == LAST);
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_bad ? DONE : SUB;
      SUB:  if (w_last) w_next = w_bout ? COMP : DONE;
      COMP: if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SUB) || (r_state == COMP);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      result   <= '0;
      neg      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            err      <= 1'b0;
            if (w_bad) begin
              result <= '0;
              neg    <= 1'b0;
              err    <= 1'b1;
            end
          end
        end
        SUB, COMP: begin
          r_part   <= w_part_next;
          r_borrow <= w_bout;
          r_idx    <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            // The complement pass always starts with a clear borrow.
            r_borrow <= 1'b0;
            if (r_state == COMP) begin
              result <= w_part_next;
              neg    <= 1'b1;
            end else if (!w_bout) begin
              result <= w_part_next;
              neg    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor: a decimal model queues expected
// result/neg/err/latency at drive time; a monitor pops and compares on done.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, err;
  logic [W-1:0] result;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         neg;
    logic         err;
    int           drv;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int drv);
    exp_t e;
    int vx = 0;
    int vy = 0;
    int diff, mag;
    bit bad = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      logic [3:0] dx, dy;
      dx = x[i*4 +: 4];
      dy = y[i*4 +: 4];
      if (dx > 9 || dy > 9) bad = 1;
      vx = vx * 10 + int'(dx);
      vy = vy * 10 + int'(dy);
    end
    e.drv = drv;
    e.res = '0;
    if (bad) begin
      e.neg = 1'b0;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      diff  = vx - vy;
      e.neg = (diff < 0);
      e.err = 1'b0;
      mag   = (diff < 0) ? -diff : diff;
      for (int i = 0; i < DIGITS; i++) begin
        e.res[i*4 +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
      e.lat = (diff < 0) ? 2 * DIGITS + 1 : DIGITS + 1;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", {16'd0, result}, {16'd0, mon_e.res});
        check("neg", {31'd0, neg}, {31'd0, mon_e.neg});
        check("err", {31'd0, err}, {31'd0, mon_e.err});
        check("latency", cyc - mon_e.drv, mon_e.lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done <= done;
  end

  // Caller sits at a negedge; start is raised for the following rising edge.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y, cyc));
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(x, y, 0);
    @(negedge clk);
    drive(x, y);
    @(negedge clk);
    start = 1'b0;
    check("busy_c1", {31'd0, busy}, e.err ? 32'd0 : 32'd1);
    if (!e.err) check("err_cleared", {31'd0, err}, 32'd0);
    drain();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result"}, {16'd0, result}, 32'd0);
    check({tag, "_neg"}, {31'd0, neg}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [W-1:0] rx, ry;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    run_op(16'h4321, 16'h1234);
    run_op(16'h1234, 16'h4321);
    run_op(16'h0000, 16'h0001);
    run_op(16'h9999, 16'h9999);
    run_op(16'h12A4, 16'h0001);
    run_op(16'h0050, 16'h0020);
    run_op(16'h0001, 16'h00F0);
    run_op(16'h0000, 16'h0000);
    run_op(16'h9999, 16'h0000);
    run_op(16'h0000, 16'h9999);

    // start while busy is ignored; operand changes after acceptance do nothing.
    @(negedge clk);
    drive(16'h4321, 16'h1234);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    a = 16'h9999;
    b = 16'h0000;
    while (cyc < c0 + 3) @(negedge clk);
    start = 1'b1;
    a = 16'h0777;
    b = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high: second acceptance in the idle cycle after DONE.
    @(negedge clk);
    drive(16'h4321, 16'h1234);
    c0 = cyc;
    @(negedge clk);
    a = 16'h0500;
    b = 16'h0123;
    sb.push_back(model(a, b, c0 + DIGITS + 2));
    while (cyc < c0 + DIGITS + 2) @(negedge clk);
    check("idle_between", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-SUB of a negative operation; start during reset is ignored.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h4321;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'h0002;
    b = 16'h0001;
    @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    run_op(16'h0100, 16'h0001);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        rx[i*4 +: 4] = 4'($urandom_range(0, 9));
        ry[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
